instr_mem_sync: RTL and testbench
=================================

Name: instr_mem_sync

Overview:
- Parametrised, clocked instruction memory for the pipelined core; replaces the combinational hard-coded program ROM.
- Word-addressed storage of DEPTH instructions, loadable at run time through a program port.
- Fetch side uses a valid/ready request and a registered valid/ready response (1-cycle latency) with fault reporting.
- On reset the block self-clears every word to NOP before accepting traffic.

Parameters:
DATA_W, 32, instruction width in bits
DEPTH, 64, number of instruction words (power of 2, >= 2)
ADDR_W, 32, byte-address width of fetch requests
NOP_INSN, 32'h00000013, fill/fault value (addi x0,x0,0)
AW = $clog2(DEPTH), derived localparam, word-index width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  fetch request valid
req_ready  out  1  block can accept fetch this cycle
req_addr  in  ADDR_W  byte address of fetch
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_instr  out  DATA_W  fetched instruction
rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range
prog_we  in  1  program-port write strobe
prog_ready  out  1  program port accepts writes
prog_addr  in  AW  word index to write
prog_data  in  DATA_W  instruction to write

Behaviour:
- Reset: clk and rst are the only clock and reset; reset is synchronous, active-high. Sampled rst=1 -> state CLEAR, clr_idx=0, rsp_valid=0, rsp_instr=NOP_INSN, rsp_fault=00; req_ready=0, prog_ready=0. Memory array is not reset directly; CLEAR overwrites it.
- FSM states: CLEAR, RUN.
- CLEAR: each cycle writes NOP_INSN to mem[clr_idx], clr_idx++. When clr_idx==DEPTH-1 is written, go to RUN on the next edge. Exactly DEPTH cycles. req_ready=0, prog_ready=0; req_valid and prog_we are ignored.
- RUN: prog_ready=1; req_ready = !rsp_valid || rsp_ready (combinational).
- Fetch accept: req_valid && req_ready at edge N -> at edge N+1 rsp_valid=1, rsp_instr/rsp_fault loaded.
- Word index = req_addr[AW+1:2].
- Fault priority: req_addr[1:0]!=0 -> fault 01, instr NOP_INSN. Else req_addr[ADDR_W-1:2] >= DEPTH (any upper bit set) -> fault 10, instr NOP_INSN. Else fault 00, instr=mem[index]. No wrap-around: out-of-range addresses never alias.
- Stall: rsp_valid && !rsp_ready -> rsp_instr, rsp_fault, rsp_valid held stable; req_ready=0.
- Drain: rsp_valid && rsp_ready && no new accept -> rsp_valid=0 next edge; rsp_instr/rsp_fault keep last value.
- Back-to-back: rsp_ready=1 with req_valid=1 every cycle -> one response per cycle, full throughput.
- Program write: prog_we && prog_ready -> mem[prog_addr]=prog_data at that edge.
- Write/read collision on the same word in the same cycle -> response returns the OLD word (read-before-write). A held (stalled) response is never altered by later writes.
- Reset mid-operation: rst overrides all; in-flight response discarded (rsp_valid=0 next edge), program contents lost via CLEAR.

Test Plan:
- Reset, DEPTH=64: hold rst 1 cycle -> req_ready=0 for exactly 64 cycles, then 1; fetch addr 0x20 -> rsp_instr=0x00000013, fault 00.
- Program words 0..3 = 0x00402083, 0x00802103, 0x001101B3, 0x00302623; fetch 0,4,8,12 back-to-back with rsp_ready=1 -> four consecutive responses in order, one per cycle, all fault 00.
- Stall: response for addr 4 valid, rsp_ready=0 for 3 cycles -> rsp_instr stays 0x00802103, req_ready=0; then rsp_ready=1 -> accepts next request in same cycle.
- Faults: fetch 0x06 -> fault 01, NOP; fetch 0x100 (word 64) -> fault 10, NOP; fetch 0x102 -> fault 01 (misaligned wins).
- Collision: word 5 = 0xAAAA0000; same cycle prog_we to word 5 with 0xBBBB0000 and fetch 0x14 -> response 0xAAAA0000; next fetch 0x14 -> 0xBBBB0000.
- Reset mid-stall: rsp_valid=1, rsp_ready=0, assert rst -> rsp_valid=0 next edge, CLEAR re-runs 64 cycles, previously programmed words read back 0x00000013.

Source files
------------

// File: rtl/instr_mem_sync.sv
// instr_mem_sync: clocked, run-time loadable instruction memory.
// After reset the array is swept to NOP_INSN one word per cycle (CLEAR),
// then fetches are served with a registered 1-cycle response (RUN).
module instr_mem_sync #(
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          DEPTH    = 64,
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [DATA_W-1:0]    NOP_INSN = 32'h00000013,
    localparam int unsigned         AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [1:0]        rsp_fault,
    input  logic              prog_we,
    output logic              prog_ready,
    input  logic [AW-1:0]     prog_addr,
    input  logic [DATA_W-1:0] prog_data
);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam logic [1:0] FLT_OK    = 2'b00;
    localparam logic [1:0] FLT_ALIGN = 2'b01;
    localparam logic [1:0] FLT_RANGE = 2'b10;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_instr_q, rsp_instr_d;
    logic [1:0]        rsp_fault_q, rsp_fault_d;

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [AW-1:0]     req_idx;
    logic              req_misaligned;
    logic              req_out_of_range;
    logic              accept;

    assign req_idx          = req_addr[AW+1:2];
    assign req_misaligned   = |req_addr[1:0];
    // Any byte-address bit above the word index means out of range; never alias.
    assign req_out_of_range = |req_addr[ADDR_W-1:AW+2];

    // Next-state, memory write port and handshake outputs.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        rsp_valid_d = rsp_valid_q;
        rsp_instr_d = rsp_instr_q;
        rsp_fault_d = rsp_fault_q;
        mem_we      = 1'b0;
        mem_waddr   = clr_idx_q;
        mem_wdata   = NOP_INSN;
        req_ready   = 1'b0;
        prog_ready  = 1'b0;
        accept      = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                prog_ready = 1'b1;
                req_ready  = !rsp_valid_q || rsp_ready;
                mem_we     = prog_we;
                mem_waddr  = prog_addr;
                mem_wdata  = prog_data;
                accept     = req_valid && req_ready;
                if (accept) begin
                    rsp_valid_d = 1'b1;
                    if (req_misaligned) begin
                        rsp_fault_d = FLT_ALIGN;
                        rsp_instr_d = NOP_INSN;
                    end else if (req_out_of_range) begin
                        rsp_fault_d = FLT_RANGE;
                        rsp_instr_d = NOP_INSN;
                    end else begin
                        rsp_fault_d = FLT_OK;
                        // Sampled before this edge's write lands: read-before-write.
                        rsp_instr_d = mem[req_idx];
                    end
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= NOP_INSN;
            rsp_fault_q <= FLT_OK;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    // Storage array: single write port, no reset (CLEAR sweeps it).
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_instr = rsp_instr_q;
    assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// tb_instr_mem_sync: directed, table-driven bench for instr_mem_sync.
module tb_instr_mem_sync;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [1:0]  rsp_fault;
    logic        prog_we;
    logic        prog_ready;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    instr_mem_sync #(
        .DATA_W   (32),
        .DEPTH    (64),
        .ADDR_W   (32),
        .NOP_INSN (32'h00000013)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_instr  (rsp_instr),
        .rsp_fault  (rsp_fault),
        .prog_we    (prog_we),
        .prog_ready (prog_ready),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pwe;
        logic [5:0]  paddr;
        logic [31:0] pdata;
        logic        rv;
        logic [31:0] raddr;
        logic        rr;
        logic        exp_rdy;
        logic        exp_v;
        logic [31:0] exp_i;
        logic [1:0]  exp_f;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic pwe, input logic [5:0] paddr, input logic [31:0] pdata,
                                input logic rv, input logic [31:0] raddr, input logic rr,
                                input logic exp_rdy, input logic exp_v, input logic [31:0] exp_i,
                                input logic [1:0] exp_f);
        vec_t v;
        v.pwe = pwe; v.paddr = paddr; v.pdata = pdata;
        v.rv = rv; v.raddr = raddr; v.rr = rr;
        v.exp_rdy = exp_rdy; v.exp_v = exp_v; v.exp_i = exp_i; v.exp_f = exp_f;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    endtask

    // Counts cycles with req_ready low after reset release; the cycle just
    // after the reset edge has already been observed low by the caller.
    task automatic wait_clear(input string name, input bit poke_prog);
        int unsigned cnt = 1;
        bit done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (poke_prog && cnt == 40) begin
                prog_we = 1'b1; prog_addr = 6'd0; prog_data = 32'hCAFEF00D;
            end else begin
                prog_we = 1'b0;
            end
            @(negedge clk);
            if (req_ready) done = 1;
            else cnt++;
        end
        prog_we = 1'b0;
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_cycles"}, cnt, 32'd64);
        chk({name, "_prog_ready"}, 32'(prog_ready), 32'd1);
    endtask

    task automatic fetch_chk(input string name, input logic [31:0] addr,
                             input logic [31:0] exp_i, input logic [1:0] exp_f);
        req_valid = 1'b1; req_addr = addr; rsp_ready = 1'b1;
        #1;
        chk({name, "_req_ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk({name, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_rsp_instr"}, rsp_instr, exp_i);
        chk({name, "_rsp_fault"}, 32'(rsp_fault), 32'(exp_f));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rsp_ready = 1'b0;
        rst = 1'b1;

        // Reset state.
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_prog_ready", 32'(prog_ready), 32'd0);
        chk("rst_rsp_instr", rsp_instr, NOP);
        chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        wait_clear("clear1", 1'b0);

        // Cycle-by-cycle table: inputs applied before an edge, outputs checked after.
        //            pwe paddr pdata          rv raddr          rr rdy v  instr          f
        tbl.push_back(mk(0, 6'd0, 32'h0,         1, 32'h20,       1, 1, 1, NOP,           2'd0));
        tbl.push_back(mk(1, 6'd0, 32'h00402083,  0, 32'h0,        1, 1, 0, NOP,           2'd0));
        tbl.push_back(mk(1, 6'd1, 32'h00802103,  0, 32'h0,        1, 1, 0, NOP,           2'd0));
        tbl.push_back(mk(1, 6'd2, 32'h001101B3,  0, 32'h0,        1, 1, 0, NOP,           2'd0));
        tbl.push_back(mk(1, 6'd3, 32'h00302623,  0, 32'h0,        1, 1, 0, NOP,           2'd0));
        tbl.push_back(mk(0, 6'd0, 32'h0,         1, 32'h0,        1, 1, 1, 32'h00402083,  2'd0));
        tbl.push_back(mk(0, 6'd0, 32'h0,         1, 32'h4,        1, 1, 1, 32'h00802103,  2'd0));
        tbl.push_back(mk(0, 6'd0, 32'h0,         1, 32'h8,        1, 1, 1, 32'h001101B3,  2'd0));
        tbl.push_back(mk(0, 6'd0, 32'h0,         1, 32'hC,        1, 1, 1, 32'h00302623,  2'd0));
        tbl.push_back(mk(0, 6'd0, 32'h0,         1, 32'h4,        1, 1, 1, 32'h00802103,  2'd0));
        tbl.push_back(mk(0, 6'd0, 32'h0,         1, 32'h8,        0, 0, 1, 32'h00802103,  2'd0));
        tbl.push_back(mk(1, 6'd1, 32'h11111111,  1, 32'h8,        0, 0, 1, 32'h00802103,  2'd0));
        tbl.push_back(mk(0, 6'd0, 32'h0,         1, 32'h8,        0, 0, 1, 32'h00802103,  2'd0));
        tbl.push_back(mk(0, 6'd0, 32'h0,         1, 32'h8,        1, 1, 1, 32'h001101B3,  2'd0));
        tbl.push_back(mk(0, 6'd0, 32'h0,         1, 32'h06,       1, 1, 1, NOP,           2'd1));
        tbl.push_back(mk(0, 6'd0, 32'h0,         1, 32'h100,      1, 1, 1, NOP,           2'd2));
        tbl.push_back(mk(0, 6'd0, 32'h0,         1, 32'h102,      1, 1, 1, NOP,           2'd1));
        tbl.push_back(mk(1, 6'd5, 32'hAAAA0000,  0, 32'h0,        1, 1, 0, NOP,           2'd1));
        tbl.push_back(mk(1, 6'd5, 32'hBBBB0000,  1, 32'h14,       1, 1, 1, 32'hAAAA0000,  2'd0));
        tbl.push_back(mk(0, 6'd0, 32'h0,         1, 32'h14,       1, 1, 1, 32'hBBBB0000,  2'd0));
        tbl.push_back(mk(0, 6'd0, 32'h0,         1, 32'h80000010, 1, 1, 1, NOP,           2'd2));
        tbl.push_back(mk(0, 6'd0, 32'h0,         1, 32'hFC,       1, 1, 1, NOP,           2'd0));
        tbl.push_back(mk(0, 6'd0, 32'h0,         1, 32'h4,        1, 1, 1, 32'h11111111,  2'd0));

        foreach (tbl[i]) begin
            prog_we = tbl[i].pwe; prog_addr = tbl[i].paddr; prog_data = tbl[i].pdata;
            req_valid = tbl[i].rv; req_addr = tbl[i].raddr; rsp_ready = tbl[i].rr;
            #1;
            chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].exp_rdy));
            @(negedge clk);
            chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].exp_v));
            chk($sformatf("vec%0d_rsp_instr", i), rsp_instr, tbl[i].exp_i);
            chk($sformatf("vec%0d_rsp_fault", i), 32'(rsp_fault), 32'(tbl[i].exp_f));
        end
        idle_inputs();

        // Reset while a response is stalled.
        fetch_chk("pre_rst_fetch", 32'h0, 32'h00402083, 2'd0);
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("stall_hold_valid", 32'(rsp_valid), 32'd1);
        chk("stall_hold_instr", rsp_instr, 32'h00402083);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_prog_ready", 32'(prog_ready), 32'd0);
        chk("midrst_rsp_instr", rsp_instr, NOP);
        // A program write late in CLEAR (word 0 already swept) must be ignored.
        wait_clear("clear2", 1'b1);
        fetch_chk("post_rst_w0", 32'h0,  NOP, 2'd0);
        fetch_chk("post_rst_w1", 32'h4,  NOP, 2'd0);
        fetch_chk("post_rst_w5", 32'h14, NOP, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
